// File: rtl/uart_pkg.sv
// =============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive path.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  // Rounded to the nearest integer divisor.
  function automatic int calc_clks_per_bit(input longint clk_hz, input longint baud);
    return int'((clk_hz + baud / 2) / baud);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// =============================================================================
// Module      : uart_rx_sync
// Description : Multi-flop synchronizer for the serial line, resets to idle (1).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_deframer.sv
// =============================================================================
// Module      : uart_rx_deframer
// Description : 8N1 UART receiver with mid-bit sampling and a one-entry
//               valid/ready holding register. UART_RX_PARITY_EN adds even parity.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      overrun
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic                      rxs;
  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_q, overrun_d;
  logic                      cnt_zero;
  logic                      stop_sample;
  logic                      commit;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      parity_err_q, parity_err_d;
  logic                      par_mismatch;
`endif

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (rx),
    .q      (rxs)
  );

  assign cnt_zero = (cnt_q == '0);
`ifdef UART_RX_PARITY_EN
  assign par_mismatch = rxs ^ (^shift_q);
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rxs) begin
          cnt_d   = CNT_HALF;
          state_d = START;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs) begin
          state_d = IDLE;
        end else begin
          cnt_d     = CNT_FULL;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d   = {rxs, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = CNT_FULL;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_bad_d = par_mismatch;
          cnt_d     = CNT_FULL;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = rxs ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stop_sample = (state_q == STOP) && cnt_zero;
`ifdef UART_RX_PARITY_EN
    commit       = stop_sample && rxs && !par_bad_q;
    parity_err_d = (state_q == PARITY) && cnt_zero && par_mismatch;
`else
    commit       = stop_sample && rxs;
`endif
    frame_err_d = stop_sample && !rxs;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    overrun_d   = 1'b0;
    // A byte may replace one being consumed this same cycle.
    if (commit) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = shift_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
// =============================================================================
// Module      : tb_uart_rx_deframer
// Description : Directed bench for uart_rx_deframer at 16 clocks per bit.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_uart_rx_deframer;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit WITH_PAR = 1'b1;
`else
  localparam bit WITH_PAR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int errors = 0;
  int checks = 0;

  int vcyc = 0, acc = 0, ferr = 0, ovr = 0, perr = 0;
  logic [7:0] last_data = 8'h00;
  int b_vcyc, b_acc, b_ferr, b_ovr, b_perr;

  always #5 clock = ~clock;

  uart_rx_deframer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .rx         (rx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun    (overrun)
  );

  always @(negedge clock) begin
    if (resetn) begin
      if (out_valid) vcyc++;
      if (out_valid && out_ready) begin
        acc++;
        last_data = out_data;
      end
      if (frame_err) ferr++;
      if (overrun) ovr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr++;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_vcyc = vcyc; b_acc = acc; b_ferr = ferr; b_ovr = ovr; b_perr = perr;
  endtask

  task automatic drive_bit(input logic v);
    @(posedge clock);
    #1 rx = v;
    repeat (CPB - 1) @(posedge clock);
  endtask

  task automatic idle(input int n);
    @(posedge clock);
    #1 rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (WITH_PAR) drive_bit(par_v);
    drive_bit(stop_v);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    resetn = 1'b1;
    idle(5);

    // Good byte with consumer ready.
    snap();
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(8);
    chk("a5_valid_cycles", vcyc - b_vcyc, 1);
    chk("a5_accepts", acc - b_acc, 1);
    chk("a5_data", last_data, 8'hA5);
    chk("a5_frame_err", ferr - b_ferr, 0);
    chk("a5_overrun", ovr - b_ovr, 0);
    chk("a5_busy", busy, 1'b0);

    // False start: short low glitch.
    snap();
    @(posedge clock);
    #1 rx = 1'b0;
    repeat (4) @(posedge clock);
    #1 rx = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("glitch_valid", vcyc - b_vcyc, 0);
    chk("glitch_busy", busy, 1'b0);
    snap();
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(8);
    chk("3c_accepts", acc - b_acc, 1);
    chk("3c_data", last_data, 8'h3C);

    // Stop bit low followed by a held-low line.
    snap();
    send_frame(8'h3C, 1'b0, ^8'h3C);
    repeat (40) @(posedge clock);
    idle(20);
    chk("brk_frame_err", ferr - b_ferr, 1);
    chk("brk_valid", vcyc - b_vcyc, 0);
    chk("brk_busy", busy, 1'b0);
    snap();
    send_frame(8'h55, 1'b1, ^8'h55);
    idle(8);
    chk("55_accepts", acc - b_acc, 1);
    chk("55_data", last_data, 8'h55);

    // Overrun with consumer stalled.
    out_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, ^8'h11);
    idle(4);
    send_frame(8'h22, 1'b1, ^8'h22);
    idle(8);
    chk("ovr_valid", out_valid, 1'b1);
    chk("ovr_data", out_data, 8'h11);
    chk("ovr_pulses", ovr - b_ovr, 1);
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(negedge clock);
    chk("ovr_valid_before_edge", out_valid, 1'b1);
    @(posedge clock);
    #1;
    chk("ovr_valid_dropped", out_valid, 1'b0);
    chk("ovr_accept_data", last_data, 8'h11);

    // Reset during bit 3 of 0xF0.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    @(posedge clock);
    #1 rx = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    chk("pre_rst_busy", busy, 1'b1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_data", out_data, 8'h00);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_frame_err", frame_err, 1'b0);
    chk("mid_rst_overrun", overrun, 1'b0);
`ifdef UART_RX_PARITY_EN
    chk("mid_rst_parity_err", parity_err, 1'b0);
`endif
    rx = 1'b1;
    repeat (5) @(posedge clock);
    #1 resetn = 1'b1;
    idle(10);
    snap();
    send_frame(8'h0F, 1'b1, ^8'h0F);
    idle(8);
    chk("0f_accepts", acc - b_acc, 1);
    chk("0f_data", last_data, 8'h0F);

`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h01, 1'b1, 1'b0);
    idle(8);
    chk("par_bad_pulse", perr - b_perr, 1);
    chk("par_bad_valid", vcyc - b_vcyc, 0);
    snap();
    send_frame(8'h01, 1'b1, 1'b1);
    idle(8);
    chk("par_ok_pulse", perr - b_perr, 0);
    chk("par_ok_data", last_data, 8'h01);
    chk("par_ok_accepts", acc - b_acc, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial-to-byte receiver for the 8N1 UART link. Decodes the rocketTop `uart_TX` stream for the system bench and for board-side loopback.
- Samples the asynchronous serial line at mid-bit using a per-bit clock counter.
- Hands each good byte out through a one-entry valid/ready holding register.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200). Legal minimum is 4.
- SYNC_STAGES, 2: flops in the input synchronizer. Legal minimum is 2.

Ports:
- clock  in  1  system clock, 100 MHz.
- resetn  in  1  asynchronous, active-low reset. One clock domain only.
- rx  in  1  serial input, idle high, asynchronous to clock.
- out_data  out  8  received byte, LSB first on the wire.
- out_valid  out  1  out_data holds an unconsumed byte.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
- busy  out  1  high whenever the FSM is not in IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good byte arrived while the holding register was still full.

Behaviour:
- Reset values: out_data=0x00, out_valid=0, busy=0, frame_err=0, overrun=0. Synchronizer flops reset to 1 (idle line). FSM resets to IDLE; counters reset to 0.
- rx passes through SYNC_STAGES flops; all decisions use the synchronized value rxs. Bit counter width is $clog2(CLKS_PER_BIT).
- IDLE: when rxs==0, load cnt=CLKS_PER_BIT/2-1 and go to START.
- START: decrement cnt. At cnt==0, sample rxs:
  - rxs==1: false start, return to IDLE.
  - rxs==0: load cnt=CLKS_PER_BIT-1, bit_idx=0, go to DATA.
- DATA: at cnt==0, shift rxs into the MSB of the shift register (right shift), increment bit_idx, reload cnt. After bit_idx reaches 7, go to STOP. Otherwise decrement cnt each cycle.
- STOP: at cnt==0 (mid stop bit), sample rxs:
  - rxs==1: commit the byte and go to IDLE in the same cycle. No wait for end of stop bit, so back-to-back frames are tolerated.
  - rxs==0: pulse frame_err, discard the byte, go to BREAK.
- BREAK: stay until rxs==1, then go to IDLE. A held-low line (break) produces exactly one frame_err.
- Commit to the holding register:
  - If out_valid==0, or out_valid && out_ready in the same cycle: load out_data, set out_valid.
  - Otherwise: keep the old byte, drop the new one, pulse overrun.
- Handshake: out_valid falls on the edge after out_valid && out_ready, unless a commit happens that same cycle. out_data is stable while out_valid is high.
- Latency: out_valid rises on the clock edge that ends the stop-bit sample cycle. From the rx falling edge that is SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles, ±1.
- Reset mid-frame: asynchronous return to reset values. A partially received byte is lost. After resetn rises, the next falling edge on rxs starts a fresh frame.
- busy = (state != IDLE).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and samples the even-parity bit.
  - A mismatch pulses the extra output parity_err (1 bit, reset 0) and discards the byte.
  - The STOP state is still traversed.
  - Frame length becomes 11 bits.
- Undefined: no PARITY state, no parity_err port; 8N1 only.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - UART_DATA_BITS=8;
  - a function computing CLKS_PER_BIT from clock and baud frequencies.
- Sub-module uart_rx_sync: parameterized SYNC_STAGES-flop synchronizer with asynchronous reset to 1.
- FSM, counters and holding register stay in uart_rx_deframer.

Test Plan (CLKS_PER_BIT=16):
- out_ready=1, send 0xA5 8N1 → exactly one out_valid cycle with out_data=0xA5. frame_err=0, overrun=0. busy low after stop.
- rx low for 4 cycles then high → no out_valid. busy returns to 0 after the START sample; next frame 0x3C is received correctly.
- Send 0x3C with stop bit low and line held low for 40 cycles → one frame_err pulse, no out_valid. Then send 0x55 → out_data=0x55.
- out_ready=0, send 0x11 then 0x22 → out_data stays 0x11, one overrun pulse. Then raise out_ready → out_valid drops one cycle later.
- Assert resetn=0 during bit 3 of 0xF0, release, send 0x0F → all outputs at reset values during reset, then out_data=0x0F.
- With UART_RX_PARITY_EN: send 0x01 with parity bit 0 → parity_err pulse, no out_valid. Send 0x01 with parity bit 1 → out_data=0x01.
